// File: rtl/cosine_sim_engine.sv
// Cosine similarity of two NUM_ELEM-element vectors, Q1.(OUT_W-1) result via start/busy/done.
// Define COSSIM_SIGNED_EN for two's-complement elements and a signed result; otherwise unsigned.
module cosine_sim_engine #(
  parameter int ELEM_W   = 8,
  parameter int NUM_ELEM = 4,
  parameter int OUT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_ELEM*ELEM_W-1:0] A_vec,
  input  logic [NUM_ELEM*ELEM_W-1:0] B_vec,
  output logic                       busy,
  output logic                       done,
  output logic [OUT_W-1:0]           cosine_similarity,
  output logic                       zero_vec
);

  localparam int ACC_W = 2*ELEM_W + $clog2(NUM_ELEM) + 1;
  localparam int VEC_W = NUM_ELEM*ELEM_W;
  localparam int P_W   = 2*ACC_W;
  localparam int REM_W = ACC_W + 3;
  localparam int CNT_W = $clog2(ACC_W + OUT_W + NUM_ELEM) + 1;
  localparam logic [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_PROD, S_SQRT, S_DIV, S_DONE} state_t;

  function automatic logic signed [ACC_W-1:0] ext_elem(input logic [ELEM_W-1:0] e);
`ifdef COSSIM_SIGNED_EN
    return ACC_W'(signed'(e));
`else
    return ACC_W'(e);
`endif
  endfunction

  function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] v);
`ifdef COSSIM_SIGNED_EN
    return v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
`else
    return $unsigned(v);
`endif
  endfunction

  // Cauchy-Schwarz bounds q by exactly 2^(OUT_W-1), so only that one value needs clamping.
  function automatic logic [OUT_W-1:0] sat_q(input logic [OUT_W-1:0] q);
    return q[OUT_W-1] ? Q_MAX : q;
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [VEC_W-1:0]          a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0]   dot_q, dot_d, na2_q, na2_d, nb2_q, nb2_d;
  logic [P_W-1:0]            p_q, p_d;
  logic signed [REM_W-1:0]   srem_q, srem_d;
  logic [ACC_W-1:0]          root_q, root_d;
  logic [ACC_W-1:0]          drem_q, drem_d;
  logic [OUT_W-1:0]          dvd_q, dvd_d, quo_q, quo_d;
  logic                      busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic [OUT_W-1:0]          cos_q, cos_d;

  logic signed [ACC_W-1:0]   ea, eb;
  logic signed [REM_W-1:0]   s_in, s_next;
  logic [ACC_W:0]            t, t_sub;
  logic                      ge;
  logic [ACC_W-1:0]          mag;
  logic [OUT_W-1:0]          res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dot_d   = dot_q;
    na2_d   = na2_q;
    nb2_d   = nb2_q;
    p_d     = p_q;
    srem_d  = srem_q;
    root_d  = root_q;
    drem_d  = drem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cos_d   = cos_q;
    zero_d  = zero_q;

    ea  = ext_elem(a_q[ELEM_W-1:0]);
    eb  = ext_elem(b_q[ELEM_W-1:0]);
    mag = magnitude(dot_q);

    // Non-restoring square root: sign of the partial remainder picks add or subtract.
    s_in   = (srem_q <<< 2) | $signed(REM_W'(p_q[P_W-1 -: 2]));
    s_next = ~srem_q[REM_W-1] ? s_in - $signed(REM_W'({root_q, 2'b01}))
                              : s_in + $signed(REM_W'({root_q, 2'b11}));

    t     = {drem_q, dvd_q[OUT_W-1]};
    t_sub = t - {1'b0, root_q};
    ge    = (t >= {1'b0, root_q});

`ifdef COSSIM_SIGNED_EN
    res = dot_q[ACC_W-1] ? -sat_q(quo_q) : sat_q(quo_q);
`else
    res = sat_q(quo_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A_vec;
          b_d     = B_vec;
          dot_d   = '0;
          na2_d   = '0;
          nb2_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        dot_d = dot_q + ea * eb;
        na2_d = na2_q + ea * ea;
        nb2_d = nb2_q + eb * eb;
        a_d   = a_q >> ELEM_W;
        b_d   = b_q >> ELEM_W;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_ELEM-1)) begin
          cnt_d   = '0;
          state_d = S_PROD;
        end
      end
      S_PROD: begin
        p_d     = P_W'($unsigned(na2_q)) * P_W'($unsigned(nb2_q));
        srem_d  = '0;
        root_d  = '0;
        state_d = S_SQRT;
      end
      S_SQRT: begin
        srem_d = s_next;
        root_d = {root_q[ACC_W-2:0], ~s_next[REM_W-1]};
        p_d    = p_q << 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ACC_W-1)) begin
          // Dividend is |dot| << (OUT_W-1); its top part |dot|>>1 is already below root.
          drem_d  = mag >> 1;
          dvd_d   = {mag[0], {(OUT_W-1){1'b0}}};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (root_q != '0) begin
          drem_d = ACC_W'(ge ? t_sub : t);
          dvd_d  = dvd_q << 1;
          quo_d  = {quo_q[OUT_W-2:0], ge};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OUT_W-1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cos_d   = (root_q == '0) ? '0 : res;
        zero_d  = (root_q == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dot_q   <= '0;
      na2_q   <= '0;
      nb2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dot_q   <= dot_d;
      na2_q   <= na2_d;
      nb2_q   <= nb2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cos_q   <= cos_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    p_q    <= p_d;
    srem_q <= srem_d;
    root_q <= root_d;
    drem_q <= drem_d;
    dvd_q  <= dvd_d;
    quo_q  <= quo_d;
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign cosine_similarity = cos_q;
  assign zero_vec          = zero_q;

endmodule
